// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM states, constants and field helpers for fp_mul_seq.
// Field helpers take the operand word zero-extended to 64 bits.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MUL    = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_PACK   = 3'd5,
    S_DONE   = 3'd6
  } fp_state_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quiet NaN: exponent all ones, fraction MSB set, sign clear.
  function automatic logic [63:0] fp_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

  function automatic logic fp_sign(input logic [63:0] x, input int n);
    return |((x >> (n - 1)) & 64'd1);
  endfunction

  function automatic logic [63:0] fp_exp(input logic [63:0] x,
                                         input int exp_w,
                                         input int man_w);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_frac(input logic [63:0] x,
                                          input int man_w);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_sig_mul.sv
// fp_sig_mul: iterative shift-add multiplier, one multiplier bit per cycle.
// start loads operands; done is high during the last of the W steps.
import fp_pkg::*;

module fp_sig_mul #(
  parameter int W = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] prod_o,
  output logic           done_o
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mc_q, mc_d;
  logic [W-1:0]   mp_q, mp_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Load on start, then add the shifted multiplicand per set multiplier bit.
  always_comb begin
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    cnt_d = cnt_q;
    if (start_i) begin
      acc_d = '0;
      mc_d  = {{W{1'b0}}, a_i};
      mp_d  = b_i;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      if (mp_q[0]) acc_d = acc_q + mc_q;
      mc_d  = mc_q << 1;
      mp_d  = mp_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
    end
  end

  assign prod_o = acc_q;
  assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential FP multiplier (unpack/mul/norm/round/pack).
// Define FP_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
import fp_pkg::*;

module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sq,
  input  logic                 r_i,
  output logic                 busy,
  output logic [EXP_W+MAN_W:0] res,
  output logic                 err,
  output logic                 unf,
  output logic                 r_o
);

  localparam int N  = EXP_W + MAN_W + 1;
  localparam int W  = MAN_W + 1;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS_C = XW'(fp_bias(EXP_W));
  localparam logic [XW-1:0] EMAX_C = XW'((1 << EXP_W) - 1);
  localparam logic [N-1:0]  NAN_C  = N'(fp_nan(EXP_W, MAN_W));

  fp_state_e st_q, st_d;

  logic [N-1:0]   a_q, b_q;
  logic           sq_q;
  logic [W-1:0]   sig_q;
  logic [XW-1:0]  exp_q;
  logic           g_q, s_q;
  logic [N-1:0]   res_q;
  logic           err_q, unf_q, ro_q;

  logic           mul_start, mul_done;
  logic [2*W-1:0] prod;

  logic               sa, sb, sgn;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, is_nan;

  logic               hi;
  logic [W-1:0]       sig_n, sig_r;
  logic [XW-1:0]      exp_n, exp_r;
  logic               g_n, s_n, inc, carry;
  logic [W:0]         sum;

  logic [N-1:0]       res_n;
  logic               err_n, unf_n;

  assign sa = fp_sign(64'(a_q), N);
  assign sb = fp_sign(64'(b_q), N);
  assign ea = EXP_W'(fp_exp(64'(a_q), EXP_W, MAN_W));
  assign eb = EXP_W'(fp_exp(64'(b_q), EXP_W, MAN_W));
  assign fa = MAN_W'(fp_frac(64'(a_q), MAN_W));
  assign fb = MAN_W'(fp_frac(64'(b_q), MAN_W));

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign is_nan = ((&ea) && (fa != '0)) || ((&eb) && (fb != '0))
               || (a_inf && b_zero) || (b_inf && a_zero);
  assign sgn    = sq_q ? 1'b0 : (sa ^ sb);

  fp_sig_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .a_i     ({1'b1, fa}),
    .b_i     ({1'b1, fb}),
    .prod_o  (prod),
    .done_o  (mul_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= S_IDLE;
    else     st_q <= st_d;
  end

  // Next-state: fixed pass through every stage, W cycles in MUL.
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:   if (r_i) st_d = S_UNPACK;
      S_UNPACK: st_d = S_MUL;
      S_MUL:    if (mul_done) st_d = S_NORM;
      S_NORM:   st_d = S_ROUND;
      S_ROUND:  st_d = S_PACK;
      S_PACK:   st_d = S_DONE;
      S_DONE:   st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (st_q != S_IDLE);
    mul_start = (st_q == S_UNPACK);
  end

  // Normalise: a product in [2,4) shifts right and bumps the exponent.
  always_comb begin
    hi    = prod[2*W-1];
    sig_n = hi ? prod[2*W-1:W] : prod[2*W-2:W-1];
    g_n   = hi ? prod[W-1] : prod[W-2];
    s_n   = hi ? (|prod[W-2:0]) : (|prod[W-3:0]);
    exp_n = {2'b00, ea} + {2'b00, eb} - BIAS_C + XW'(hi);
  end

`ifdef FP_ROUND_NEAREST_EN
  assign inc = g_q & (s_q | sig_q[0]);
`else
  logic unused_rnd;
  assign inc        = 1'b0;
  assign unused_rnd = g_q ^ s_q;
`endif

  // Round: a carry out of the significand renormalises to 1.0.
  always_comb begin
    sum   = {1'b0, sig_q} + (W + 1)'(inc);
    carry = sum[W];
    sig_r = carry ? sum[W:1] : sum[W-1:0];
    exp_r = exp_q + XW'(carry);
  end

  // Pack: specials first, then range checks on the rounded exponent.
  always_comb begin
    res_n = '0;
    err_n = 1'b0;
    unf_n = 1'b0;
    if (is_nan) begin
      res_n = NAN_C;
    end else if (a_inf || b_inf) begin
      res_n = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      res_n = {sgn, {(N-1){1'b0}}};
    end else if (!exp_q[XW-1] && (exp_q >= EMAX_C)) begin
      res_n = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      err_n = 1'b1;
    end else if (exp_q[XW-1] || (exp_q == '0)) begin
      res_n = {sgn, {(N-1){1'b0}}};
      unf_n = 1'b1;
    end else begin
      res_n = {sgn, exp_q[EXP_W-1:0], sig_q[MAN_W-1:0]};
    end
  end

  // Datapath registers: operand capture, normalise and round results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sq_q  <= 1'b0;
      sig_q <= '0;
      exp_q <= '0;
      g_q   <= 1'b0;
      s_q   <= 1'b0;
    end else begin
      if (st_q == S_IDLE && r_i) begin
        a_q  <= a;
        b_q  <= sq ? a : b;
        sq_q <= sq;
      end
      if (st_q == S_NORM) begin
        sig_q <= sig_n;
        exp_q <= exp_n;
        g_q   <= g_n;
        s_q   <= s_n;
      end
      if (st_q == S_ROUND) begin
        sig_q <= sig_r;
        exp_q <= exp_r;
      end
    end
  end

  // Result registers load entering DONE; r_o pulses on leaving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      err_q <= 1'b0;
      unf_q <= 1'b0;
      ro_q  <= 1'b0;
    end else begin
      if (st_q == S_PACK) begin
        res_q <= res_n;
        err_q <= err_n;
        unf_q <= unf_n;
      end
      ro_q <= (st_q == S_DONE);
    end
  end

  assign res = res_q;
  assign err = err_q;
  assign unf = unf_q;
  assign r_o = ro_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed and random checks of fp_mul_seq against a
// reference built on exact double-precision products.
`timescale 1ns/1ps

module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        sq, r_i;
  logic        busy;
  logic [31:0] res;
  logic        err, unf, r_o;

  int n_cmp = 0;
  int n_bad = 0;

  fp_mul_seq dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .sq   (sq),
    .r_i  (r_i),
    .busy (busy),
    .res  (res),
    .err  (err),
    .unf  (unf),
    .r_o  (r_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {res, err, unf}. Normal operands are multiplied exactly in
  // double precision, then rounded/range-checked to single format.
  function automatic logic [33:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] yi,
                                          input logic sqm);
    logic [31:0] y;
    logic        s, g, st;
    logic [7:0]  xe, ye;
    logic [22:0] xf, yf;
    logic [63:0] dbits;
    logic [23:0] m;
    real         p;
    int          e;
    y  = sqm ? x : yi;
    s  = sqm ? 1'b0 : (x[31] ^ y[31]);
    xe = x[30:23];
    ye = y[30:23];
    xf = x[22:0];
    yf = y[22:0];
    if ((xe == 8'hFF && xf != 0) || (ye == 8'hFF && yf != 0) ||
        (xe == 8'hFF && ye == 0) || (ye == 8'hFF && xe == 0))
      return {32'h7FC00000, 2'b00};
    if (xe == 8'hFF || ye == 8'hFF)
      return {s, 8'hFF, 23'd0, 2'b00};
    if (xe == 0 || ye == 0)
      return {s, 31'd0, 2'b00};
    p = $bitstoreal({1'b0, 11'(xe) + 11'd896, xf, 29'd0})
      * $bitstoreal({1'b0, 11'(ye) + 11'd896, yf, 29'd0});
    dbits = $realtobits(p);
    e  = int'(dbits[62:52]) - 1023 + 127;
    m  = {1'b0, dbits[51:29]};
    g  = dbits[28];
    st = |dbits[27:0];
`ifdef FP_ROUND_NEAREST_EN
    if (g && (st || m[0])) m = m + 24'd1;
`else
    if (g && st && 1'b0) m = m + 24'd1;
`endif
    if (m[23]) begin
      m = 24'd0;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 2'b10};
    if (e <= 0)   return {s, 31'd0, 2'b01};
    return {s, 8'(e), m[22:0], 2'b00};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int          k;
    logic [7:0]  e;
    logic [22:0] f;
    k = $urandom_range(0, 9);
    f = 23'($urandom);
    if (k < 6)       e = 8'($urandom_range(100, 154));
    else if (k == 6) e = 8'($urandom_range(1, 75));
    else if (k == 7) e = 8'($urandom_range(180, 254));
    else if (k == 8) e = 8'd0;
    else begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = 23'd0;
    end
    return {1'($urandom), e, f};
  endfunction

  // One full transaction: accept, measure latency, compare with model.
  task automatic run_op(input string tag, input logic [31:0] ta,
                        input logic [31:0] tb, input logic tsq,
                        output logic [31:0] ores, output logic oerr,
                        output logic ounf);
    logic [33:0] e;
    int          lat;
    @(negedge clk);
    a   = ta;
    b   = tb;
    sq  = tsq;
    r_i = 1'b1;
    @(posedge clk);
    #1 r_i = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!r_o && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd29);
    e = ref_mul(ta, tb, tsq);
    check({tag, "_res"}, 64'(res), 64'(e[33:2]));
    check({tag, "_err"}, 64'(err), 64'(e[1]));
    check({tag, "_unf"}, 64'(unf), 64'(e[0]));
    ores = res;
    oerr = err;
    ounf = unf;
    @(posedge clk);
    #1 check({tag, "_ro_one"}, 64'(r_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e1, u1;
    int          pulses, pcyc;

    rst = 1'b1;
    r_i = 1'b0;
    a   = '0;
    b   = '0;
    sq  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res",  64'(res),  64'd0);
    check("rst_err",  64'(err),  64'd0);
    check("rst_unf",  64'(unf),  64'd0);
    check("rst_ro",   64'(r_o),  64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("sq3", 32'h40400000, 32'h0, 1'b1, r, e1, u1);
    check("sq3_c", 64'(r), 64'h41100000);

    run_op("rnd1", 32'h3F800001, 32'h3FC00000, 1'b0, r, e1, u1);
`ifdef FP_ROUND_NEAREST_EN
    check("rnd1_c", 64'(r), 64'h3FC00002);
`else
    check("rnd1_c", 64'(r), 64'h3FC00001);
`endif

    run_op("ovf", 32'h7F000000, 32'h0, 1'b1, r, e1, u1);
    check("ovf_c", 64'(r), 64'h7F800000);
    check("ovf_e", 64'(e1), 64'd1);
    run_op("one", 32'h3F800000, 32'h0, 1'b1, r, e1, u1);
    check("one_c", 64'(r), 64'h3F800000);
    check("one_e", 64'(e1), 64'd0);

    run_op("udf", 32'h1F800000, 32'h0, 1'b1, r, e1, u1);
    check("udf_c", 64'(r), 64'h0);
    check("udf_u", 64'(u1), 64'd1);

    run_op("infz", 32'h7F800000, 32'h00000000, 1'b0, r, e1, u1);
    check("infz_c", 64'(r), 64'h7FC00000);
    run_op("ninf", 32'hFF800000, 32'h40000000, 1'b0, r, e1, u1);
    check("ninf_c", 64'(r), 64'hFF800000);

    // Reset in MUL cycle 10 aborts with no r_o pulse.
    @(negedge clk);
    a   = 32'h40000000;
    sq  = 1'b1;
    r_i = 1'b1;
    @(posedge clk);
    #1 r_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst_res",  64'(res),  64'd0);
    check("mrst_err",  64'(err),  64'd0);
    check("mrst_unf",  64'(unf),  64'd0);
    check("mrst_ro",   64'(r_o),  64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 if (r_o) pulses++;
    end
    check("mrst_nopulse", 64'(pulses), 64'd0);

    run_op("rest", 32'h40000000, 32'h0, 1'b1, r, e1, u1);
    check("rest_c", 64'(r), 64'h40800000);

    // r_i during busy is ignored.
    @(negedge clk);
    a   = 32'h40400000;
    sq  = 1'b1;
    r_i = 1'b1;
    @(posedge clk);
    #1 r_i = 1'b0;
    pulses = 0;
    pcyc   = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin
        a   = 32'h3F800000;
        r_i = 1'b1;
      end
      if (c == 7) r_i = 1'b0;
      @(posedge clk);
      #1;
      if (r_o) begin
        pulses++;
        pcyc = c;
      end
    end
    check("bsy_pulses", 64'(pulses), 64'd1);
    check("bsy_lat",    64'(pcyc),   64'd29);
    check("bsy_res",    64'(res),    64'h41100000);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = rnd_fp();
      y = rnd_fp();
      run_op("rand", x, y, 1'($urandom_range(0, 3) == 0), r, e1, u1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
